sq_window_accum: RTL and testbench
==================================

// Module: sq_window_accum
// PURPOSE
//  Downstream companion to the altsquare integer squarer: windowed sum-of-squares (energy) accumulator.
//  Tracks a sample valid through the squarer's fixed pipeline, so squared results are consumed only when real.
//  Sums WINDOW consecutive valid squares and presents each total on a valid/ready output port.
//  Used for power/energy measurement in the NLB sample datapath.
// PARAMETERS
//  SQ_WIDTH     16  width of squarer result (matches squarer result_width)
//  SQ_PIPELINE   0  squarer pipeline depth in ena-qualified clocks (0 = combinational)
//  ACC_WIDTH    40  accumulator / output width; must be >= SQ_WIDTH
//  WINDOW       16  samples per sum; >= 1
// PORTS
//  clock      in   1          rising-edge clock, shared with squarer
//  aclr_n     in   1          asynchronous active-low reset; squarer aclr is driven by ~aclr_n
//  ena        in   1          clock enable, same net as squarer ena
//  in_valid   in   1          sample presented to squarer data this cycle
//  sq_data    in   SQ_WIDTH   squarer result output
//  flush      in   1          synchronous discard of the partial window
//  clr_ovr    in   1          synchronous clear of ovr
//  out_valid  out  1          out_data holds a completed window sum
//  out_ready  in   1          consumer accepts out_data
//  out_data   out  ACC_WIDTH  window sum of squares
//  out_sat    out  1          this sum saturated (see CONFIGURATION)
//  ovr        out  1          sticky: a completed sum was dropped
// BEHAVIOUR
//  Reset (aclr_n=0, async): delay line, acc, cnt, out_valid, out_data, out_sat, ovr all 0.
//  Valid tracking: sq_vld = in_valid delayed through SQ_PIPELINE stages; stages shift only when ena=1.
//   SQ_PIPELINE=0: sq_vld = in_valid combinationally.
//  Accumulate (ena=1 and sq_vld=1 and flush=0):
//   cnt < WINDOW-1: acc <= acc + zext(sq_data); cnt <= cnt+1.
//   cnt == WINDOW-1: total = acc + sq_data; acc <= 0; cnt <= 0; total goes to output stage.
//  ena=0: delay line, acc, cnt frozen; sq_vld ignored. Output handshake and ovr logic still run.
//  flush=1 (ena ignored): acc <= 0; cnt <= 0; any sample that cycle is discarded; output stage untouched.
//  Output stage:
//   Load when completion and (out_valid=0 or out_ready=1): out_data <= total, out_valid <= 1, out_sat set.
//   Completion while out_valid=1 and out_ready=0: total dropped, ovr <= 1, held out_data unchanged.
//   out_ready=1 with no completion: out_valid <= 0 (out_data holds value).
//   Same-cycle accept and completion: new total loaded, out_valid stays 1.
//  ovr: sticky until clr_ovr=1; if clr_ovr and a drop occur in the same cycle, ovr=1.
//  Latency: out_valid rises 1 clock after the clock in which the last sample's sq_vld is seen.
//   With ena=1 throughout: SQ_PIPELINE+1 clocks after its in_valid.
//  WINDOW=1: every valid square is output directly.
//  cnt width: $clog2(WINDOW)+1. No combinational path from out_ready to out_valid.
// CONFIGURATION
//  SQ_ACC_SATURATE_EN defined:
//   Any add overflowing ACC_WIDTH clamps acc to all-ones for the rest of the window.
//   A window sum that clamped is output with out_sat=1.
//  SQ_ACC_SATURATE_EN undefined: sums wrap modulo 2^ACC_WIDTH; out_sat tied 0.
// TESTING
//  Setup: SQ_PIPELINE=2, WINDOW=4, ena=1.
//   in_valid 4 cycles, squares 1,4,9,16 -> out_data=30, out_valid rises 3 clocks after last in_valid.
//  Backpressure: out_ready=0 across two windows (30 then 120) -> out_data holds 30, ovr=1.
//   Then out_ready=1 -> 30 accepted, out_valid falls; clr_ovr pulse -> ovr=0.
//  ena low 5 clocks mid-window after 2 samples -> cnt/acc frozen.
//   Remaining 2 samples after ena=1 -> sum still 30, no extra samples counted.
//  flush after 3 samples (sum 14) -> partial discarded; next 4 samples 1,1,1,1 -> out_data=4.
//  ACC_WIDTH=16, WINDOW=2, squares 65000,1000:
//   macro off -> out_data=464, out_sat=0; macro on -> out_data=65535, out_sat=1.
//  aclr_n low mid-window with out_valid=1 -> all outputs 0 immediately (async, before next edge).
//   Next window after release sums from 0.

Source files
------------

// File: rtl/sq_window_accum.sv
// Windowed sum-of-squares accumulator sitting behind a fixed-latency squarer.
// Latency: out_valid rises 1 clock after the last sample's square is seen (SQ_PIPELINE+1 after in_valid).
// Backpressure: a completed sum that cannot be loaded is dropped and ovr is set; no out_ready->out_valid path.
// Optional: define SQ_ACC_SATURATE_EN to clamp overflowing windows to all-ones and flag them on out_sat.
module sq_window_accum #(
  parameter int SQ_WIDTH    = 16,
  parameter int SQ_PIPELINE = 0,
  parameter int ACC_WIDTH   = 40,
  parameter int WINDOW      = 16
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [SQ_WIDTH-1:0]  sq_data,
  input  logic                 flush,
  input  logic                 clr_ovr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 ovr
);

  localparam int CNT_W = $clog2(WINDOW) + 1;

  logic                 w_sq_vld;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_done;
  logic                 w_load;
  logic                 w_drop;
  logic [ACC_WIDTH-1:0] w_total;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_ovr;

  // Valid companion to the squarer pipeline: shifts only when the squarer does.
  generate
    if (SQ_PIPELINE == 0) begin : g_nopipe
      assign w_sq_vld = in_valid;
    end else begin : g_pipe
      logic [SQ_PIPELINE-1:0] r_vld_pipe;
      // Delay in_valid by the squarer's ena-qualified depth.
      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          r_vld_pipe <= '0;
        end else if (ena) begin
          r_vld_pipe[0] <= in_valid;
          for (int i = 1; i < SQ_PIPELINE; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
          end
        end
      end
      assign w_sq_vld = r_vld_pipe[SQ_PIPELINE-1];
    end
  endgenerate

  // flush has priority; it only squashes the accumulate path, never the output stage.
  assign w_accept = ena & w_sq_vld;
  assign w_last   = (r_cnt == CNT_W'(WINDOW - 1));
  assign w_done   = w_accept & ~flush & w_last;
  assign w_load   = w_done & (~r_out_valid | out_ready);
  assign w_drop   = w_done & r_out_valid & ~out_ready;

`ifdef SQ_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  logic               w_clamp;
  logic               r_clamped;
  logic               r_out_sat;

  // Once a window overflows it stays pinned at all-ones until it completes or is flushed.
  assign w_sum_ext = {1'b0, r_acc} + (ACC_WIDTH+1)'(sq_data);
  assign w_clamp   = w_sum_ext[ACC_WIDTH] | r_clamped;
  assign w_total   = w_clamp ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];

  // Remember that the current window has clamped.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_clamped <= 1'b0;
    end else if (flush) begin
      r_clamped <= 1'b0;
    end else if (w_accept) begin
      r_clamped <= w_last ? 1'b0 : w_clamp;
    end
  end

  // Saturation flag travels with the loaded sum.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_out_sat <= 1'b0;
    end else if (w_load) begin
      r_out_sat <= w_clamp;
    end
  end

  assign out_sat = r_out_sat;
`else
  // Sums wrap modulo 2^ACC_WIDTH.
  assign w_total = r_acc + ACC_WIDTH'(sq_data);
  assign out_sat = 1'b0;
`endif

  // Window accumulator and sample counter; frozen while ena is low.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_total;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Single-entry output register with valid/ready handshake.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_total;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as clr_ovr wins.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_sq_window_accum.sv
// Directed bench for sq_window_accum with a scoreboard of expected window sums.
// Instance a: SQ_PIPELINE=2, WINDOW=4 fed by a small squarer model; instance b: ACC_WIDTH=16, WINDOW=2.
// Summary line reports total comparisons and failures.
module tb_sq_window_accum;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        ena;
  logic        flush;
  logic        clr_ovr;

  logic        a_in_valid;
  logic [7:0]  a_in_d;
  logic [15:0] a_sq_p1, a_sq_p2;
  logic        a_out_ready;
  logic        a_out_valid;
  logic [39:0] a_out_data;
  logic        a_out_sat;
  logic        a_ovr;

  logic        b_in_valid;
  logic [15:0] b_sq_data;
  logic        b_out_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic        b_out_sat;
  logic        b_ovr;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clock = ~clock;

  // Two-stage squarer model, ena-qualified, aclr driven by ~aclr_n.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      a_sq_p1 <= '0;
      a_sq_p2 <= '0;
    end else if (ena) begin
      a_sq_p1 <= 16'(a_in_d) * 16'(a_in_d);
      a_sq_p2 <= a_sq_p1;
    end
  end

  sq_window_accum #(.SQ_WIDTH(16), .SQ_PIPELINE(2), .ACC_WIDTH(40), .WINDOW(4)) u_a (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .in_valid(a_in_valid), .sq_data(a_sq_p2),
    .flush(flush), .clr_ovr(clr_ovr), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat), .ovr(a_ovr)
  );

  sq_window_accum #(.SQ_WIDTH(16), .SQ_PIPELINE(0), .ACC_WIDTH(16), .WINDOW(2)) u_b (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .in_valid(b_in_valid), .sq_data(b_sq_data),
    .flush(flush), .clr_ovr(clr_ovr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat), .ovr(b_ovr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; on the way, retire any handshake on instance a against the scoreboard.
  task automatic tick();
    logic [63:0] e;
    @(negedge clock);
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 64'(a_out_data), e);
        chk("sb_sat", 64'(a_out_sat), 64'd0);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] d);
    a_in_valid = 1'b1;
    a_in_d     = d;
    tick();
  endtask

  task automatic idle_a(input int n);
    a_in_valid = 1'b0;
    a_in_d     = 8'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    aclr_n = 1'b0; ena = 1'b1; flush = 1'b0; clr_ovr = 1'b0;
    a_in_valid = 1'b0; a_in_d = 8'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_sq_data = 16'd0; b_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_out_sat", 64'(a_out_sat), 64'd0);
    chk("rst_ovr", 64'(a_ovr), 64'd0);
    #12 aclr_n = 1'b1;
    @(posedge clock); #1;

    // Narrow accumulator: 65000 + 1000 overflows 16 bits.
    b_in_valid = 1'b1; b_sq_data = 16'd65000; tick();
    b_sq_data = 16'd1000; tick();
    b_in_valid = 1'b0; b_sq_data = 16'd0;
    chk("b_out_valid", 64'(b_out_valid), 64'd1);
`ifdef SQ_ACC_SATURATE_EN
    chk("b_out_data", 64'(b_out_data), 64'd65535);
    chk("b_out_sat", 64'(b_out_sat), 64'd1);
`else
    chk("b_out_data", 64'(b_out_data), 64'd464);
    chk("b_out_sat", 64'(b_out_sat), 64'd0);
`endif
    tick();

    // Basic window 1,4,9,16 and latency from last in_valid.
    drive_a(8'd1); drive_a(8'd2); drive_a(8'd3);
    exp_q.push_back(64'd30);
    a_in_valid = 1'b1; a_in_d = 8'd4;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      a_in_valid = 1'b0; a_in_d = 8'd0;
      lat++;
      if (a_out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    chk("first_sum", 64'(a_out_data), 64'd30);
    idle_a(2);

    // Backpressure across two windows: second sum (120) is dropped.
    a_out_ready = 1'b0;
    exp_q.push_back(64'd30);
    drive_a(8'd1); drive_a(8'd2); drive_a(8'd3); drive_a(8'd4);
    drive_a(8'd2); drive_a(8'd4); drive_a(8'd6); drive_a(8'd8);
    idle_a(4);
    chk("bp_held_data", 64'(a_out_data), 64'd30);
    chk("bp_held_valid", 64'(a_out_valid), 64'd1);
    chk("bp_ovr_set", 64'(a_ovr), 64'd1);
    a_out_ready = 1'b1;
    tick();
    chk("bp_valid_fall", 64'(a_out_valid), 64'd0);
    chk("bp_ovr_sticky", 64'(a_ovr), 64'd1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("bp_ovr_clear", 64'(a_ovr), 64'd0);

    // ena low for 5 clocks after 2 samples; samples offered meanwhile are not taken.
    exp_q.push_back(64'd30);
    drive_a(8'd1); drive_a(8'd2);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) drive_a(8'd7);
    chk("ena_no_output", 64'(a_out_valid), 64'd0);
    ena = 1'b1;
    drive_a(8'd3); drive_a(8'd4);
    idle_a(5);

    // Flush after a partial window of 1,4,9 then a fresh window of ones.
    drive_a(8'd1); drive_a(8'd2); drive_a(8'd3);
    idle_a(3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_no_output", 64'(a_out_valid), 64'd0);
    exp_q.push_back(64'd4);
    drive_a(8'd1); drive_a(8'd1); drive_a(8'd1); drive_a(8'd1);
    idle_a(5);

    // Async reset mid-window while a sum is held; outputs clear before any edge.
    a_out_ready = 1'b0;
    drive_a(8'd1); drive_a(8'd2); drive_a(8'd3); drive_a(8'd4);
    drive_a(8'd1); drive_a(8'd1);
    idle_a(4);
    chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
    #2 aclr_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_out_data", 64'(a_out_data), 64'd0);
    chk("arst_ovr", 64'(a_ovr), 64'd0);
    aclr_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    exp_q.push_back(64'd16);
    drive_a(8'd2); drive_a(8'd2); drive_a(8'd2); drive_a(8'd2);
    idle_a(6);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
